// File: rtl/mem_resp_if.sv
// Memory bus bundle (req/gnt/rvalid) between a requester and mem_resp_slave.
// Signal names keep the responder's view: *_i are driven by the master and *_o are driven by the slave.
interface mem_resp_if;
    logic        req_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic        gnt_o;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        error_o;

    modport master (
        output req_i, addr_i, wdata_i, we_i, be_i,
        input  gnt_o, rvalid_o, rdata_o, error_o
    );

    modport slave (
        input  req_i, addr_i, wdata_i, we_i, be_i,
        output gnt_o, rvalid_o, rdata_o, error_o
    );
endinterface

// File: rtl/mem_resp_slave.sv
// Single-port word SRAM responder: one transaction at a time, byte-masked writes, fixed read latency.
// Optional macro MEM_RESP_GNT_STALL_EN holds off each grant until req_i has been high for GNT_STALL idle cycles.
module mem_resp_slave #(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0010_0000,
    parameter int unsigned LATENCY   = 1,
    parameter int unsigned GNT_STALL = 2
) (
    input  logic       clk,
    input  logic       reset,
    mem_resp_if.slave  bus
);
    localparam int unsigned IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_r;
    logic [3:0]  cnt_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic        we_r;
    logic [3:0]  be_r;
    logic        rvalid_r;
    logic [31:0] rdata_r;
    logic        error_r;
    logic [31:0] mem_r [DEPTH];

    logic             stall_ok_s;
    logic             gnt_s;
    logic             enter_resp_s;
    logic [31:0]      txn_addr_s;
    logic [31:0]      txn_wdata_s;
    logic             txn_we_s;
    logic [3:0]       txn_be_s;
    logic [31:0]      off_s;
    logic             err_s;
    logic [IDX_W-1:0] idx_s;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_word;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) begin
                res[8*k +: 8] = new_word[8*k +: 8];
            end else begin
                res[8*k +: 8] = old_word[8*k +: 8];
            end
        end
        return res;
    endfunction

`ifdef MEM_RESP_GNT_STALL_EN
    logic [7:0] stall_cnt_r;

    // Count consecutive idle cycles with a pending request, saturating at GNT_STALL.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_r <= 8'd0;
        end else if ((state_r != ST_IDLE) || !bus.req_i || gnt_s) begin
            stall_cnt_r <= 8'd0;
        end else if ({24'd0, stall_cnt_r} < 32'(GNT_STALL)) begin
            stall_cnt_r <= stall_cnt_r + 8'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_ok_s = ({24'd0, stall_cnt_r} >= 32'(GNT_STALL));
`else
    assign stall_ok_s = 1'b1;
`endif

    // Grant decode, transaction source select and address check.
    always_comb begin
        gnt_s        = 1'b0;
        enter_resp_s = 1'b0;
        txn_addr_s   = addr_r;
        txn_wdata_s  = wdata_r;
        txn_we_s     = we_r;
        txn_be_s     = be_r;
        if (state_r == ST_IDLE) begin
            // With zero latency the edge that grants is also the one entering RESP, so use the live bus.
            gnt_s       = bus.req_i & stall_ok_s;
            txn_addr_s  = bus.addr_i;
            txn_wdata_s = bus.wdata_i;
            txn_we_s    = bus.we_i;
            txn_be_s    = bus.be_i;
        end else begin
            gnt_s = 1'b0;
        end
        case (state_r)
            ST_IDLE: enter_resp_s = gnt_s && (LATENCY == 0);
            ST_WAIT: enter_resp_s = (cnt_r == 4'd0);
            default: enter_resp_s = 1'b0;
        endcase
        off_s = txn_addr_s - BASE_ADDR;
        err_s = (txn_addr_s[1:0] != 2'b00) || ({2'b00, off_s[31:2]} >= 32'(DEPTH));
        idx_s = off_s[IDX_W+1:2];
    end

    // Storage has no reset so its contents survive one; an abandoned write never reaches RESP.
    always_ff @(posedge clk) begin
        if (enter_resp_s && txn_we_s && !err_s) begin
            mem_r[idx_s] <= merge_bytes(mem_r[idx_s], txn_wdata_s, txn_be_s);
        end
    end

    // Transaction FSM with registered response outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 4'd0;
            addr_r   <= 32'h0;
            wdata_r  <= 32'h0;
            we_r     <= 1'b0;
            be_r     <= 4'b0000;
            rvalid_r <= 1'b0;
            rdata_r  <= 32'h0;
            error_r  <= 1'b0;
        end else begin
            rvalid_r <= 1'b0;
            rdata_r  <= 32'h0;
            error_r  <= 1'b0;
            if (enter_resp_s) begin
                rvalid_r <= 1'b1;
                error_r  <= err_s;
                rdata_r  <= (!err_s && !txn_we_s) ? mem_r[idx_s] : 32'h0;
            end
            case (state_r)
                ST_IDLE: begin
                    if (gnt_s) begin
                        addr_r  <= bus.addr_i;
                        wdata_r <= bus.wdata_i;
                        we_r    <= bus.we_i;
                        be_r    <= bus.be_i;
                        if (LATENCY == 0) begin
                            state_r <= ST_RESP;
                        end else begin
                            state_r <= ST_WAIT;
                            cnt_r   <= CNT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == 4'd0) begin
                        state_r <= ST_RESP;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_RESP: state_r <= ST_IDLE;
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign bus.gnt_o    = gnt_s;
    assign bus.rvalid_o = rvalid_r;
    assign bus.rdata_o  = rdata_r;
    assign bus.error_o  = error_r;

endmodule

// File: tb/tb_mem_resp_slave.sv
// Self-checking bench for mem_resp_slave: directed scenarios plus random traffic against a word-level model.
module tb_mem_resp_slave;
    localparam int unsigned DEPTH     = 1024;
    localparam logic [31:0] BASE_ADDR = 32'h0010_0000;
    localparam int unsigned LATENCY   = 1;
`ifdef MEM_RESP_GNT_STALL_EN
    localparam int STALL_EXP = 2;
`else
    localparam int STALL_EXP = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] mdl [int];

    mem_resp_if bus ();

    mem_resp_slave #(
        .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR), .LATENCY(LATENCY), .GNT_STALL(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_err(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return ((a % 32'd4) != 32'd0) || ((off / 32'd4) >= 32'(DEPTH));
    endfunction

    function automatic int word_idx(input logic [31:0] a);
        return int'((a - BASE_ADDR) / 32'd4);
    endfunction

    // One full transaction; inputs are scrambled after the grant to prove they were latched.
    task automatic txn(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] b,
                       output logic [31:0] rd, output logic er);
        int waited;
        int gcyc;
        bit seen;
        bus.req_i = 1'b1; bus.addr_i = a; bus.we_i = w; bus.wdata_i = d; bus.be_i = b;
        waited = 0; seen = 1'b0;
        while (!seen && waited < 40) begin
            @(negedge clk);
            if (bus.gnt_o === 1'b1) seen = 1'b1; else waited++;
        end
        chk("gnt_delay", 32'(waited), 32'(STALL_EXP));
        gcyc = cyc;
        @(posedge clk); #1;
        bus.req_i = 1'b0; bus.addr_i = $urandom(); bus.wdata_i = $urandom();
        bus.we_i = ~w; bus.be_i = ~b;
        waited = 0; seen = 1'b0;
        while (!seen && waited < 40) begin
            @(negedge clk);
            if (bus.rvalid_o === 1'b1) seen = 1'b1; else waited++;
        end
        chk("rvalid_latency", 32'(cyc), 32'(gcyc + 1 + int'(LATENCY)));
        rd = bus.rdata_o;
        er = bus.error_o;
        @(negedge clk);
        chk("rvalid_pulse_width", {31'd0, bus.rvalid_o}, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic check_txn(input string tag, input logic [31:0] a, input logic w,
                             input logic [31:0] d, input logic [3:0] b);
        logic [31:0] rd;
        logic [31:0] exp_rd;
        logic        er;
        logic        exp_er;
        int          idx;
        exp_er = exp_err(a);
        idx    = exp_er ? -1 : word_idx(a);
        exp_rd = 32'h0;
        if (!exp_er && !w && mdl.exists(idx)) exp_rd = mdl[idx];
        txn(a, w, d, b, rd, er);
        chk({tag, "_error"}, {31'd0, er}, {31'd0, exp_er});
        if (exp_er || w || mdl.exists(idx)) chk({tag, "_rdata"}, rd, exp_rd);
        if (!exp_er && w) begin
            if (!mdl.exists(idx)) mdl[idx] = 32'h0;
            for (int k = 0; k < 4; k++) begin
                if (b[k]) mdl[idx][8*k +: 8] = d[8*k +: 8];
            end
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] rd;
        logic [31:0] rd1;
        logic [3:0]  b;
        logic        w;
        logic        er;
        int          sel;
        int          g1;
        int          r1;
        int          g2;
        int          n;
        bit          overlap;

        reset = 1'b1;
        bus.req_i = 1'b0; bus.addr_i = 32'h0; bus.wdata_i = 32'h0; bus.we_i = 1'b0; bus.be_i = 4'h0;
        repeat (3) @(negedge clk);
        chk("reset_rvalid", {31'd0, bus.rvalid_o}, 32'd0);
        chk("reset_rdata", bus.rdata_o, 32'h0);
        chk("reset_error", {31'd0, bus.error_o}, 32'd0);
        chk("reset_gnt_idle", {31'd0, bus.gnt_o}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Write then read back
        check_txn("wr_deadbeef", 32'h0010_0004, 1'b1, 32'hDEAD_BEEF, 4'hF);
        txn(32'h0010_0004, 1'b0, 32'h0, 4'hF, rd, er);
        chk("rd_deadbeef", rd, 32'hDEAD_BEEF);
        chk("rd_deadbeef_err", {31'd0, er}, 32'd0);

        // Byte-masked write
        check_txn("preload", 32'h0010_0010, 1'b1, 32'h1122_3344, 4'hF);
        check_txn("mask_wr", 32'h0010_0010, 1'b1, 32'hAABB_CCDD, 4'b0101);
        txn(32'h0010_0010, 1'b0, 32'h0, 4'hF, rd, er);
        chk("mask_rd", rd, 32'h11BB_33DD);

        // Error cases and an empty byte mask
        check_txn("err_above", 32'h0010_1000, 1'b0, 32'h0, 4'hF);
        check_txn("last_word", 32'h0010_0FFC, 1'b1, 32'h0BAD_F00D, 4'hF);
        check_txn("last_word_rd", 32'h0010_0FFC, 1'b0, 32'h0, 4'hF);
        check_txn("word0_wr", 32'h0010_0000, 1'b1, 32'h5555_AAAA, 4'hF);
        check_txn("err_misalign", 32'h0010_0002, 1'b1, 32'hFFFF_FFFF, 4'hF);
        check_txn("word0_rd", 32'h0010_0000, 1'b0, 32'h0, 4'hF);
        check_txn("err_below", 32'h000F_FFFC, 1'b0, 32'h0, 4'hF);
        check_txn("be_zero_wr", 32'h0010_0000, 1'b1, 32'h1234_5678, 4'h0);
        check_txn("be_zero_rd", 32'h0010_0000, 1'b0, 32'h0, 4'hF);

        // Back-to-back reads with req_i held high
        bus.req_i = 1'b1; bus.we_i = 1'b0; bus.be_i = 4'hF; bus.addr_i = 32'h0010_0004;
        n = 0;
        while (bus.gnt_o !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        g1 = cyc;
        @(posedge clk); #1;
        bus.addr_i = 32'h0010_0010;
        r1 = -1; g2 = -1; overlap = 1'b0; rd1 = 32'h0;
        for (int i = 0; i < 30 && g2 < 0; i++) begin
            @(negedge clk);
            if (bus.rvalid_o === 1'b1 && r1 < 0) begin r1 = cyc; rd1 = bus.rdata_o; end
            if (bus.gnt_o === 1'b1) begin
                if (r1 < 0 || bus.rvalid_o === 1'b1) overlap = 1'b1;
                g2 = cyc;
            end
        end
        chk("b2b_first_rvalid", 32'(r1), 32'(g1 + 1 + int'(LATENCY)));
        chk("b2b_first_rdata", rd1, mdl[word_idx(32'h0010_0004)]);
        chk("b2b_second_gnt", 32'(g2), 32'(r1 + 1 + STALL_EXP));
        chk("b2b_no_overlap", {31'd0, overlap}, 32'd0);
        @(posedge clk); #1;
        bus.req_i = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (bus.rvalid_o !== 1'b1 && n < 40);
        chk("b2b_second_rvalid", 32'(cyc), 32'(g2 + 1 + int'(LATENCY)));
        chk("b2b_second_rdata", bus.rdata_o, mdl[word_idx(32'h0010_0010)]);
        @(posedge clk); #1;

        // Reset during WAIT of a write abandons it
        check_txn("rst_preload", 32'h0010_0008, 1'b1, 32'h0, 4'hF);
        bus.req_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = 32'h0010_0008;
        bus.wdata_i = 32'h1234_5678; bus.be_i = 4'hF;
        n = 0;
        while (bus.gnt_o !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        bus.req_i = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_mid_rvalid", {31'd0, bus.rvalid_o}, 32'd0);
        chk("rst_mid_error", {31'd0, bus.error_o}, 32'd0);
        overlap = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.rvalid_o !== 1'b0 || bus.rdata_o !== 32'h0) overlap = 1'b1;
        end
        chk("rst_mid_quiet", {31'd0, overlap}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check_txn("rst_mid_rd", 32'h0010_0008, 1'b0, 32'h0, 4'hF);

`ifdef MEM_RESP_GNT_STALL_EN
        // Dropping req_i before the grant restarts the stall count
        bus.we_i = 1'b0; bus.addr_i = 32'h0010_0004; bus.be_i = 4'hF;
        bus.req_i = 1'b1;
        @(negedge clk);
        chk("stall_t0", {31'd0, bus.gnt_o}, 32'd0);
        @(posedge clk); #1;
        bus.req_i = 1'b0;
        @(negedge clk);
        chk("stall_drop", {31'd0, bus.gnt_o}, 32'd0);
        @(posedge clk); #1;
        bus.req_i = 1'b1;
        @(negedge clk);
        chk("stall_restart0", {31'd0, bus.gnt_o}, 32'd0);
        @(negedge clk);
        chk("stall_restart1", {31'd0, bus.gnt_o}, 32'd0);
        @(negedge clk);
        chk("stall_restart2", {31'd0, bus.gnt_o}, 32'd1);
        @(posedge clk); #1;
        bus.req_i = 1'b0;
        repeat (LATENCY + 2) @(posedge clk);
        #1;
`endif

        // Random traffic against the word model
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 9);
            a = BASE_ADDR + (32'($urandom_range(0, 15)) << 2);
            if (sel == 0) a = a + 32'($urandom_range(1, 3));
            else if (sel == 1) a = BASE_ADDR + 32'(DEPTH * 4) + (32'($urandom_range(0, 63)) << 2);
            else if (sel == 2) a = BASE_ADDR - (32'($urandom_range(1, 8)) << 2);
            w = 1'($urandom_range(0, 1));
            d = $urandom();
            b = 4'($urandom_range(0, 15));
            if (w && !exp_err(a) && !mdl.exists(word_idx(a))) b = 4'hF;
            check_txn("rand", a, w, d, b);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
